// File: rtl/tri_wave_seq_if.sv
// Command/configuration and waveform-output bundle for the triangle-wave sequencer.
// master drives commands and config; slave (the sequencer) drives the waveform outputs.
interface tri_wave_seq_if;
  logic       start;
  logic       stop;
  logic [8:0] cfg_peak;
  logic [3:0] cfg_step;
  logic       cfg_mode;
  logic [7:0] cfg_periods;
  logic [8:0] d_out;
  logic       busy;
  logic       phase;
  logic [7:0] period_cnt;
  logic       done;
  logic       cfg_err;

  modport master (
    output start, stop, cfg_peak, cfg_step, cfg_mode, cfg_periods,
    input  d_out, busy, phase, period_cnt, done, cfg_err
  );

  modport slave (
    input  start, stop, cfg_peak, cfg_step, cfg_mode, cfg_periods,
    output d_out, busy, phase, period_cnt, done, cfg_err
  );
endinterface

// File: rtl/tri_wave_seq.sv
// Start/stop-controlled triangle/sawtooth generator with a configurable peak, step and
// period count. All outputs are registered; the configuration is latched when a start is accepted.
module tri_wave_seq (
  input  logic          clk,
  input  logic          res,
  tri_wave_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic [1:0] state;
  logic [8:0] peak_q;
  logic [3:0] step_q;
  logic       mode_q;
  logic [7:0] periods_q;

  logic [8:0] d_q;
  logic       busy_q;
  logic       phase_q;
  logic [7:0] cnt_q;
  logic       done_q;
  logic       err_q;

  logic [8:0] step_ext;
  logic [9:0] sum_w;
  logic [8:0] up_next;
  logic [8:0] dn_next;
  logic [8:0] top_next;
  logic [8:0] first_up;
  logic [7:0] cnt_inc;
  logic       last_period;
  logic       cfg_ok;

  // Saturating next values; the sum is formed at 10 bits so peak values near 511 cannot wrap.
  always_comb begin
    step_ext    = {5'd0, step_q};
    sum_w       = {1'b0, d_q} + {1'b0, step_ext};
    up_next     = (sum_w > {1'b0, peak_q}) ? peak_q : sum_w[8:0];
    dn_next     = (d_q > step_ext) ? (d_q - step_ext) : '0;
    top_next    = (peak_q > step_ext) ? (peak_q - step_ext) : '0;
    first_up    = (step_ext > peak_q) ? peak_q : step_ext;
    cnt_inc     = cnt_q + 8'd1;
    last_period = (periods_q != '0) && (cnt_inc == periods_q);
    cfg_ok      = (bus.cfg_peak != '0) && (bus.cfg_step != '0);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= ST_IDLE;
      peak_q    <= '0;
      step_q    <= '0;
      mode_q    <= 1'b0;
      periods_q <= '0;
      d_q       <= '0;
      busy_q    <= 1'b0;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          d_q     <= '0;
          busy_q  <= 1'b0;
          phase_q <= 1'b0;
          if (bus.start) begin
            if (cfg_ok) begin
              peak_q    <= bus.cfg_peak;
              step_q    <= bus.cfg_step;
              mode_q    <= bus.cfg_mode;
              periods_q <= bus.cfg_periods;
              cnt_q     <= '0;
              state     <= ST_UP;
              busy_q    <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ST_UP: begin
          if (bus.stop) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            phase_q <= 1'b0;
            d_q     <= '0;
          end else if (d_q < peak_q) begin
            d_q <= up_next;
          end else if (!mode_q) begin
            state   <= ST_DOWN;
            phase_q <= 1'b1;
            d_q     <= top_next;
          end else begin
            // Sawtooth wrap is the period end; the final one replaces the wrap with completion.
            cnt_q <= cnt_inc;
            d_q   <= '0;
            if (last_period) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end

        ST_DOWN: begin
          if (bus.stop) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            phase_q <= 1'b0;
            d_q     <= '0;
          end else if (d_q != '0) begin
            d_q <= dn_next;
          end else begin
            cnt_q   <= cnt_inc;
            phase_q <= 1'b0;
            if (last_period) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              d_q    <= '0;
            end else begin
              state <= ST_UP;
              d_q   <= first_up;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          busy_q  <= 1'b0;
          phase_q <= 1'b0;
          d_q     <= '0;
        end
      endcase
    end
  end

  assign bus.d_out      = d_q;
  assign bus.busy       = busy_q;
  assign bus.phase      = phase_q;
  assign bus.period_cnt = cnt_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_tri_wave_seq.sv
// Scoreboard bench for tri_wave_seq: directed runs push hand-derived samples, and a monitor
// pops and compares one entry whenever the sequencer shows busy, done or cfg_err.
module tb_tri_wave_seq;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  tri_wave_seq_if bus ();

  tri_wave_seq dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       phase;
    logic [7:0] cnt;
    logic [8:0] d;
  } obs_t;

  obs_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  task automatic push(input logic b, input logic dn, input logic er, input logic ph,
                      input int cnt, input int d);
    obs_t e;
    e.busy  = b;
    e.done  = dn;
    e.err   = er;
    e.phase = ph;
    e.cnt   = cnt[7:0];
    e.d     = d[8:0];
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic start_run(input int pk, input int st, input int md, input int per);
    bus.cfg_peak    = pk[8:0];
    bus.cfg_step    = st[3:0];
    bus.cfg_mode    = md[0];
    bus.cfg_periods = per[7:0];
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d expected samples left, required 0", name, q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    obs_t got;
    obs_t e;
    if (mon_en) begin
      got.busy  = bus.busy;
      got.done  = bus.done;
      got.err   = bus.cfg_err;
      got.phase = bus.phase;
      got.cnt   = bus.period_cnt;
      got.d     = bus.d_out;
      checks++;
      if (got.busy || got.done || got.err) begin
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got busy=%0b done=%0b err=%0b d=%0d phase=%0b cnt=%0d, required no output",
                   got.busy, got.done, got.err, got.d, got.phase, got.cnt);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL sample: got busy=%0b done=%0b err=%0b d=%0d phase=%0b cnt=%0d, required busy=%0b done=%0b err=%0b d=%0d phase=%0b cnt=%0d",
                     got.busy, got.done, got.err, got.d, got.phase, got.cnt,
                     e.busy, e.done, e.err, e.d, e.phase, e.cnt);
          end
        end
      end else if (got.d !== 9'd0 || got.phase !== 1'b0) begin
        failures++;
        $display("FAIL idle_out: got d=%0d phase=%0b, required d=0 phase=0", got.d, got.phase);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d1[17];
    int ph1[17];
    int d3[13];
    int ph3[13];
    int pat[4];

    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.cfg_peak = '0;
    bus.cfg_step = '0;
    bus.cfg_mode = 1'b0;
    bus.cfg_periods = '0;
    repeat (3) @(negedge clk);
    chk("rst_d_out", bus.d_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_phase", bus.phase, 0);
    chk("rst_period_cnt", bus.period_cnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    res = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Triangle, peak=4 step=1, two periods
    d1  = '{0,1,2,3,4,3,2,1,0,1,2,3,4,3,2,1,0};
    ph1 = '{0,0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1};
    for (int k = 0; k < 17; k++) push(1'b1, 1'b0, 1'b0, ph1[k][0], (k < 9) ? 0 : 1, d1[k]);
    push(1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    start_run(4, 1, 0, 2);
    drain("tri_4_1");

    // Sawtooth, peak=3 step=1, three periods
    for (int k = 0; k < 12; k++) push(1'b1, 1'b0, 1'b0, 1'b0, k / 4, k % 4);
    push(1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
    start_run(3, 1, 1, 3);
    drain("saw_3_1");

    // peak=10 step=4 continuous; cfg change and start while busy mid-run, then stop
    d3  = '{0,4,8,10,6,2,0,4,8,10,6,2,0};
    ph3 = '{0,0,0,0,1,1,1,0,0,0,1,1,1};
    for (int k = 0; k < 13; k++) push(1'b1, 1'b0, 1'b0, ph3[k][0], (k < 7) ? 0 : 1, d3[k]);
    start_run(10, 4, 0, 0);
    repeat (5) @(negedge clk);
    bus.cfg_peak = 9'd1;
    bus.cfg_step = 4'd1;
    bus.cfg_mode = 1'b1;
    bus.cfg_periods = 8'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop_busy", bus.busy, 0);
    chk("stop_cnt_hold", bus.period_cnt, 1);
    drain("tri_10_4");

    // Step larger than peak: peak=3 step=5, two periods
    push(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
    push(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1, 3);
    push(1'b1, 1'b0, 1'b0, 1'b1, 1, 0);
    push(1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    start_run(3, 5, 0, 2);
    drain("tri_3_5");

    // Continuous peak=2 step=1 long enough for period_cnt to wrap, then abort
    pat = '{1,2,1,0};
    for (int k = 0; k < 1040; k++) begin
      if (k == 0) push(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      else push(1'b1, 1'b0, 1'b0, ((k - 1) % 4) >= 2, ((k - 1) / 4) % 256, pat[(k - 1) % 4]);
    end
    start_run(2, 1, 0, 0);
    repeat (1039) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("wrap_cnt_hold", bus.period_cnt, 3);
    chk("wrap_stop_done", bus.done, 0);
    drain("cont_wrap");

    // Illegal starts: peak=0, then step=0
    push(1'b0, 1'b0, 1'b1, 1'b0, 3, 0);
    start_run(0, 1, 0, 1);
    push(1'b0, 1'b0, 1'b1, 1'b0, 3, 0);
    start_run(5, 0, 0, 1);
    drain("cfg_err");

    // start+stop together in IDLE is accepted; stop on the final period end suppresses done
    push(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
    push(1'b1, 1'b0, 1'b0, 1'b0, 0, 2);
    push(1'b1, 1'b0, 1'b0, 1'b1, 0, 1);
    push(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    bus.stop = 1'b1;
    start_run(2, 1, 0, 1);
    bus.stop = 1'b0;
    repeat (4) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("abort_cnt_hold", bus.period_cnt, 0);
    drain("final_stop");

    // Reset mid-DOWN, then an immediate restart
    for (int k = 0; k < 8; k++) begin
      if (k == 0) push(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      else push(1'b1, 1'b0, 1'b0, ((k - 1) % 4) >= 2, (k - 1) / 4, pat[(k - 1) % 4]);
    end
    start_run(2, 1, 0, 0);
    repeat (7) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    chk("mid_rst_d_out", bus.d_out, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_phase", bus.phase, 0);
    chk("mid_rst_period_cnt", bus.period_cnt, 0);
    chk("mid_rst_done", bus.done, 0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 0, 2);
    push(1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    start_run(2, 2, 1, 1);
    drain("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
